// File: rtl/spike_layer_config_loader.sv
// Configuration loader for a spiking neuron layer: collects 13 bytes into a shadow
// register and commits weights/parameters atomically, with an idle-gap timeout.
module spike_layer_config_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        enable_in,
    output logic [71:0] input_weights,
    output logic [31:0] neuron_params,
    output logic        layer_enable,
    output logic        config_valid,
    output logic        config_done,
    output logic        busy,
    output logic        error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [103:0]   shadow_q;
    logic [3:0]     byte_cnt_q;
    logic [TW-1:0]  idle_cnt_q;
    logic           accept;
    logic           restart;
    logic           timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // load_start takes priority over data_valid in LOAD; COMMIT ignores both inputs.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        restart = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    restart = 1'b1;
                end
            end
            LOAD: begin
                if (load_start) begin
                    restart = 1'b1;
                end else if (data_valid) begin
                    accept = 1'b1;
                    if (byte_cnt_q == 4'd12) begin
                        state_d = COMMIT;
                    end
                end else if (idle_cnt_q == IDLE_LIMIT) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q      <= '0;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            input_weights <= '0;
            neuron_params <= '0;
            config_valid  <= 1'b0;
            config_done   <= 1'b0;
            error         <= 1'b0;
        end else begin
            config_done <= 1'b0;

            if (restart) begin
                shadow_q   <= '0;
                byte_cnt_q <= '0;
                idle_cnt_q <= '0;
                error      <= 1'b0;
            end

            if (accept) begin
                // Byte k lands at shadow[103-8k -: 8]; the low 32 bits become neuron_params.
                for (int unsigned k = 0; k < 13; k++) begin
                    if (byte_cnt_q == 4'(k)) begin
                        shadow_q[103 - 8*k -: 8] <= data_in;
                    end
                end
                byte_cnt_q <= byte_cnt_q + 4'd1;
                idle_cnt_q <= '0;
            end else if (state_q == LOAD && !load_start && !data_valid) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end

            if (timeout) begin
                shadow_q   <= '0;
                byte_cnt_q <= '0;
                idle_cnt_q <= '0;
                error      <= 1'b1;
            end

            if (state_q == COMMIT) begin
                input_weights <= shadow_q[103:32];
                neuron_params <= shadow_q[31:0];
                config_valid  <= 1'b1;
                config_done   <= 1'b1;
                byte_cnt_q    <= '0;
                idle_cnt_q    <= '0;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign layer_enable = enable_in & config_valid;

endmodule
